// File: rtl/pipe_pkg.sv
// Shared definitions for the ID->EX pipeline register: stage states, ctrl bit map
// and default widths.
package pipe_pkg;

    localparam int DEF_N  = 32;
    localparam int DEF_RW = 5;
    localparam int DEF_C  = 5;

    localparam int CTRL_WR_EN    = 0;
    localparam int CTRL_OPB_SEL  = 1;
    localparam int CTRL_ALU_FUNC = 2;
    localparam int CTRL_WD_SEL   = 3;
    localparam int CTRL_WM       = 4;

    typedef enum logic [1:0] {
        EMPTY     = 2'd0,
        FULL      = 2'd1,
        SKID_FULL = 2'd2
    } stage_state_t;

    function automatic logic [1:0] state_occupancy(input stage_state_t s);
        case (s)
            FULL:      return 2'd1;
            SKID_FULL: return 2'd2;
            default:   return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One payload register of the ID->EX stage: operands, immediate, addresses, ctrl.
// Loads on i_load; cleared asynchronously by reset.
module pipe_slot #(
    parameter int N  = 32,
    parameter int RW = 5,
    parameter int C  = 5
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          i_load,
    input  logic [N-1:0]  i_rda,
    input  logic [N-1:0]  i_rdb,
    input  logic [N-1:0]  i_extended,
    input  logic [RW-1:0] i_ra,
    input  logic [RW-1:0] i_rb,
    input  logic [RW-1:0] i_rw,
    input  logic [C-1:0]  i_ctrl,
    output logic [N-1:0]  o_rda,
    output logic [N-1:0]  o_rdb,
    output logic [N-1:0]  o_extended,
    output logic [RW-1:0] o_ra,
    output logic [RW-1:0] o_rb,
    output logic [RW-1:0] o_rw,
    output logic [C-1:0]  o_ctrl
);

    // NOTE: payload is reset here so _ex outputs read 0 out of reset; it is a
    // handful of flops, not a memory array, so the reset costs nothing real.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            o_rda      <= '0;
            o_rdb      <= '0;
            o_extended <= '0;
            o_ra       <= '0;
            o_rb       <= '0;
            o_rw       <= '0;
            o_ctrl     <= '0;
        end else if (i_load) begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            o_rda      <= i_rda;
            o_rdb      <= i_rdb;
            o_extended <= i_extended;
            o_ra       <= i_ra;
            o_rb       <= i_rb;
            o_rw       <= i_rw;
            o_ctrl     <= i_ctrl;
        end
    end

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID->EX pipeline register with valid/ready handshake, flush, and an optional
// skid entry that makes ready_id a registered signal.
module id_ex_stage_reg
    import pipe_pkg::*;
#(
    parameter int N    = DEF_N,
    parameter int RW   = DEF_RW,
    parameter int C    = DEF_C,
    parameter int SKID = 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          valid_id,
    output logic          ready_id,
    input  logic [N-1:0]  rda_id,
    input  logic [N-1:0]  rdb_id,
    input  logic [N-1:0]  extended_id,
    input  logic [RW-1:0] ra_id,
    input  logic [RW-1:0] rb_id,
    input  logic [RW-1:0] rw_id,
    input  logic [C-1:0]  ctrl_id,
    input  logic          flush,
    output logic          valid_ex,
    input  logic          ready_ex,
    output logic [N-1:0]  rda_ex,
    output logic [N-1:0]  rdb_ex,
    output logic [N-1:0]  extended_ex,
    output logic [RW-1:0] ra_ex,
    output logic [RW-1:0] rb_ex,
    output logic [RW-1:0] rw_ex,
    output logic [C-1:0]  ctrl_ex,
    output logic [1:0]    occupancy
);

    stage_state_t  r_state;
    stage_state_t  w_state_next;
    logic          w_in_fire;
    logic          w_out_fire;
    logic          w_load_main;
    logic          w_load_skid;
    logic          w_main_from_skid;

    logic [N-1:0]  w_skid_rda, w_skid_rdb, w_skid_ext;
    logic [RW-1:0] w_skid_ra, w_skid_rb, w_skid_rw;
    logic [C-1:0]  w_skid_ctrl;

    logic [N-1:0]  w_main_rda_d, w_main_rdb_d, w_main_ext_d;
    logic [RW-1:0] w_main_ra_d, w_main_rb_d, w_main_rw_d;
    logic [C-1:0]  w_main_ctrl_d;
    logic [C-1:0]  w_main_ctrl;

    assign w_in_fire  = valid_id & ready_id;
    assign w_out_fire = valid_ex & ready_ex;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= EMPTY;
        else        r_state <= w_state_next;
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        w_state_next     = r_state;
        w_load_main      = 1'b0;
        w_load_skid      = 1'b0;
        w_main_from_skid = 1'b0;
        if (flush) begin
            w_state_next = EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_in_fire) begin
                        w_load_main  = 1'b1;
                        w_state_next = FULL;
                    end
                end
                FULL: begin
                    if (w_in_fire && w_out_fire) begin
                        w_load_main = 1'b1;
                    end else if (w_in_fire && SKID != 0) begin
                        w_load_skid  = 1'b1;
                        w_state_next = SKID_FULL;
                    end else if (w_out_fire) begin
                        w_state_next = EMPTY;
                    end
                end
                SKID_FULL: begin
                    if (w_out_fire) begin
                        w_load_main      = 1'b1;
                        w_main_from_skid = 1'b1;
                        w_state_next     = FULL;
                    end
                end
                default: w_state_next = EMPTY;
            endcase
        end
    end

    // Main slot refills from the skid entry when one is waiting, else from ID.
    assign w_main_rda_d  = w_main_from_skid ? w_skid_rda  : rda_id;
    assign w_main_rdb_d  = w_main_from_skid ? w_skid_rdb  : rdb_id;
    assign w_main_ext_d  = w_main_from_skid ? w_skid_ext  : extended_id;
    assign w_main_ra_d   = w_main_from_skid ? w_skid_ra   : ra_id;
    assign w_main_rb_d   = w_main_from_skid ? w_skid_rb   : rb_id;
    assign w_main_rw_d   = w_main_from_skid ? w_skid_rw   : rw_id;
    assign w_main_ctrl_d = w_main_from_skid ? w_skid_ctrl : ctrl_id;

    pipe_slot #(.N(N), .RW(RW), .C(C)) u_main (
        .clock      (clock),
        .reset      (reset),
        .i_load     (w_load_main),
        .i_rda      (w_main_rda_d),
        .i_rdb      (w_main_rdb_d),
        .i_extended (w_main_ext_d),
        .i_ra       (w_main_ra_d),
        .i_rb       (w_main_rb_d),
        .i_rw       (w_main_rw_d),
        .i_ctrl     (w_main_ctrl_d),
        .o_rda      (rda_ex),
        .o_rdb      (rdb_ex),
        .o_extended (extended_ex),
        .o_ra       (ra_ex),
        .o_rb       (rb_ex),
        .o_rw       (rw_ex),
        .o_ctrl     (w_main_ctrl)
    );

    generate
        if (SKID != 0) begin : g_skid
            logic r_ready_id;

            // Registered ready: low exactly while the skid entry is occupied.
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) r_ready_id <= 1'b1;
                else        r_ready_id <= (w_state_next != SKID_FULL);
            end
            assign ready_id = r_ready_id;

            pipe_slot #(.N(N), .RW(RW), .C(C)) u_skid (
                .clock      (clock),
                .reset      (reset),
                .i_load     (w_load_skid),
                .i_rda      (rda_id),
                .i_rdb      (rdb_id),
                .i_extended (extended_id),
                .i_ra       (ra_id),
                .i_rb       (rb_id),
                .i_rw       (rw_id),
                .i_ctrl     (ctrl_id),
                .o_rda      (w_skid_rda),
                .o_rdb      (w_skid_rdb),
                .o_extended (w_skid_ext),
                .o_ra       (w_skid_ra),
                .o_rb       (w_skid_rb),
                .o_rw       (w_skid_rw),
                .o_ctrl     (w_skid_ctrl)
            );
        end else begin : g_no_skid
            assign ready_id    = !valid_ex | ready_ex;
            assign w_skid_rda  = '0;
            assign w_skid_rdb  = '0;
            assign w_skid_ext  = '0;
            assign w_skid_ra   = '0;
            assign w_skid_rb   = '0;
            assign w_skid_rw   = '0;
            assign w_skid_ctrl = '0;
        end
    endgenerate

    assign valid_ex  = (r_state != EMPTY);
    assign occupancy = state_occupancy(r_state);
    // Bubbles never carry wr_en/wm into EX.
    assign ctrl_ex   = valid_ex ? w_main_ctrl : '0;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed bench for id_ex_stage_reg: one instance with SKID=1, one with SKID=0,
// sharing clock and reset.
module tb_id_ex_stage_reg;

    localparam int N  = 32;
    localparam int RW = 5;
    localparam int C  = 5;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // SKID=1 instance signals
    logic          s_valid_id = 0, s_ready_id, s_flush = 0, s_valid_ex, s_ready_ex = 0;
    logic [N-1:0]  s_rda_id = 0, s_rdb_id = 0, s_ext_id = 0;
    logic [RW-1:0] s_ra_id = 0, s_rb_id = 0, s_rw_id = 0;
    logic [C-1:0]  s_ctrl_id = 0;
    logic [N-1:0]  s_rda_ex, s_rdb_ex, s_ext_ex;
    logic [RW-1:0] s_ra_ex, s_rb_ex, s_rw_ex;
    logic [C-1:0]  s_ctrl_ex;
    logic [1:0]    s_occ;

    // SKID=0 instance signals
    logic          n_valid_id = 0, n_ready_id, n_flush = 0, n_valid_ex, n_ready_ex = 0;
    logic [N-1:0]  n_rda_id = 0, n_rdb_id = 0, n_ext_id = 0;
    logic [RW-1:0] n_ra_id = 0, n_rb_id = 0, n_rw_id = 0;
    logic [C-1:0]  n_ctrl_id = 0;
    logic [N-1:0]  n_rda_ex, n_rdb_ex, n_ext_ex;
    logic [RW-1:0] n_ra_ex, n_rb_ex, n_rw_ex;
    logic [C-1:0]  n_ctrl_ex;
    logic [1:0]    n_occ;

    id_ex_stage_reg #(.N(N), .RW(RW), .C(C), .SKID(1)) dut_skid (
        .clock(clock), .reset(reset),
        .valid_id(s_valid_id), .ready_id(s_ready_id),
        .rda_id(s_rda_id), .rdb_id(s_rdb_id), .extended_id(s_ext_id),
        .ra_id(s_ra_id), .rb_id(s_rb_id), .rw_id(s_rw_id), .ctrl_id(s_ctrl_id),
        .flush(s_flush), .valid_ex(s_valid_ex), .ready_ex(s_ready_ex),
        .rda_ex(s_rda_ex), .rdb_ex(s_rdb_ex), .extended_ex(s_ext_ex),
        .ra_ex(s_ra_ex), .rb_ex(s_rb_ex), .rw_ex(s_rw_ex), .ctrl_ex(s_ctrl_ex),
        .occupancy(s_occ)
    );

    id_ex_stage_reg #(.N(N), .RW(RW), .C(C), .SKID(0)) dut_noskid (
        .clock(clock), .reset(reset),
        .valid_id(n_valid_id), .ready_id(n_ready_id),
        .rda_id(n_rda_id), .rdb_id(n_rdb_id), .extended_id(n_ext_id),
        .ra_id(n_ra_id), .rb_id(n_rb_id), .rw_id(n_rw_id), .ctrl_id(n_ctrl_id),
        .flush(n_flush), .valid_ex(n_valid_ex), .ready_ex(n_ready_ex),
        .rda_ex(n_rda_ex), .rdb_ex(n_rdb_ex), .extended_ex(n_ext_ex),
        .ra_ex(n_ra_ex), .rb_ex(n_rb_ex), .rw_ex(n_rw_ex), .ctrl_ex(n_ctrl_ex),
        .occupancy(n_occ)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        n_checks++; if (s_valid_ex !== 1'b0) begin n_fail++; $display("FAIL reset s_valid_ex got %b exp 0", s_valid_ex); end
        n_checks++; if (s_occ !== 2'd0) begin n_fail++; $display("FAIL reset s_occ got %0d exp 0", s_occ); end
        n_checks++; if (s_ready_id !== 1'b1) begin n_fail++; $display("FAIL reset s_ready_id got %b exp 1", s_ready_id); end
        n_checks++; if (s_rda_ex !== 32'h0 || s_ctrl_ex !== 5'h0 || s_rw_ex !== 5'h0) begin n_fail++; $display("FAIL reset s_payload rda %h ctrl %h rw %h exp 0", s_rda_ex, s_ctrl_ex, s_rw_ex); end
        n_checks++; if (n_valid_ex !== 1'b0 || n_occ !== 2'd0) begin n_fail++; $display("FAIL reset n_state valid %b occ %0d exp 0/0", n_valid_ex, n_occ); end
        n_checks++; if (n_ready_id !== 1'b1) begin n_fail++; $display("FAIL reset n_ready_id got %b exp 1", n_ready_id); end
    endtask

    task automatic test_streaming();
        s_ready_ex = 1'b1;
        s_valid_id = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            s_rda_id = 32'(i);
            tick();
            n_checks++; if (s_valid_ex !== 1'b1 || s_rda_ex !== 32'(i)) begin n_fail++; $display("FAIL stream[%0d] valid %b rda %h exp 1/%h", i, s_valid_ex, s_rda_ex, 32'(i)); end
            n_checks++; if (s_occ !== 2'd1 || s_ready_id !== 1'b1) begin n_fail++; $display("FAIL stream_occ[%0d] occ %0d ready %b exp 1/1", i, s_occ, s_ready_id); end
        end
        s_valid_id = 1'b0;
        tick();
        n_checks++; if (s_valid_ex !== 1'b0 || s_occ !== 2'd0) begin n_fail++; $display("FAIL stream_drain valid %b occ %0d exp 0/0", s_valid_ex, s_occ); end
    endtask

    task automatic test_stall();
        s_ready_ex = 1'b0;
        s_valid_id = 1'b1; s_rda_id = 32'hAAAA;
        tick();
        n_checks++; if (s_rda_ex !== 32'hAAAA || s_occ !== 2'd1 || s_ready_id !== 1'b1) begin n_fail++; $display("FAIL stall_a rda %h occ %0d ready %b exp aaaa/1/1", s_rda_ex, s_occ, s_ready_id); end
        s_rda_id = 32'hBBBB;
        tick();
        n_checks++; if (s_rda_ex !== 32'hAAAA || s_occ !== 2'd2 || s_ready_id !== 1'b0) begin n_fail++; $display("FAIL stall_b rda %h occ %0d ready %b exp aaaa/2/0", s_rda_ex, s_occ, s_ready_id); end
        s_rda_id = 32'hCCCC;
        tick();
        n_checks++; if (s_rda_ex !== 32'hAAAA || s_occ !== 2'd2 || s_ready_id !== 1'b0) begin n_fail++; $display("FAIL stall_hold rda %h occ %0d ready %b exp aaaa/2/0", s_rda_ex, s_occ, s_ready_id); end
        s_ready_ex = 1'b1;
        tick();
        n_checks++; if (s_rda_ex !== 32'hBBBB || s_occ !== 2'd1 || s_ready_id !== 1'b1) begin n_fail++; $display("FAIL stall_rel_b rda %h occ %0d ready %b exp bbbb/1/1", s_rda_ex, s_occ, s_ready_id); end
        tick();
        n_checks++; if (s_rda_ex !== 32'hCCCC || s_valid_ex !== 1'b1) begin n_fail++; $display("FAIL stall_rel_c rda %h valid %b exp cccc/1", s_rda_ex, s_valid_ex); end
        s_valid_id = 1'b0;
        tick();
        n_checks++; if (s_valid_ex !== 1'b0) begin n_fail++; $display("FAIL stall_drain valid %b exp 0", s_valid_ex); end
    endtask

    task automatic test_flush();
        s_ready_ex = 1'b0;
        s_valid_id = 1'b1; s_rda_id = 32'h1111; s_ctrl_id = 5'h1F;
        tick();
        s_rda_id = 32'h2222;
        tick();
        n_checks++; if (s_occ !== 2'd2) begin n_fail++; $display("FAIL flush_fill occ %0d exp 2", s_occ); end
        s_rda_id = 32'hDDDD; s_flush = 1'b1;
        tick();
        n_checks++; if (s_valid_ex !== 1'b0 || s_occ !== 2'd0 || s_ctrl_ex !== 5'h0) begin n_fail++; $display("FAIL flush_skid valid %b occ %0d ctrl %h exp 0/0/0", s_valid_ex, s_occ, s_ctrl_ex); end
        n_checks++; if (s_ready_id !== 1'b1) begin n_fail++; $display("FAIL flush_ready ready %b exp 1", s_ready_id); end
        s_flush = 1'b0; s_valid_id = 1'b0; s_ready_ex = 1'b1;
        tick();
        n_checks++; if (s_valid_ex !== 1'b0) begin n_fail++; $display("FAIL flush_no_d valid %b rda %h exp 0", s_valid_ex, s_rda_ex); end
        // Flush from FULL while the incoming entry actually fires.
        s_ready_ex = 1'b0;
        s_valid_id = 1'b1; s_rda_id = 32'h3333;
        tick();
        s_rda_id = 32'hEEEE; s_flush = 1'b1;
        tick();
        n_checks++; if (s_valid_ex !== 1'b0 || s_occ !== 2'd0) begin n_fail++; $display("FAIL flush_full valid %b occ %0d exp 0/0", s_valid_ex, s_occ); end
        s_flush = 1'b0; s_valid_id = 1'b0; s_ctrl_id = 5'h0;
        tick();
        n_checks++; if (s_valid_ex !== 1'b0) begin n_fail++; $display("FAIL flush_full_after valid %b exp 0", s_valid_ex); end
    endtask

    task automatic test_bubble();
        s_ready_ex = 1'b1;
        s_valid_id = 1'b1; s_ctrl_id = 5'b11111;
        s_rda_id = 32'h55; s_rdb_id = 32'h66; s_ext_id = 32'h77;
        s_ra_id = 5'd1; s_rb_id = 5'd2; s_rw_id = 5'd3;
        tick();
        n_checks++; if (s_ctrl_ex !== 5'b11111 || s_valid_ex !== 1'b1) begin n_fail++; $display("FAIL bubble_live ctrl %b valid %b exp 11111/1", s_ctrl_ex, s_valid_ex); end
        n_checks++; if (s_rdb_ex !== 32'h66 || s_ext_ex !== 32'h77 || s_ra_ex !== 5'd1 || s_rb_ex !== 5'd2 || s_rw_ex !== 5'd3) begin n_fail++; $display("FAIL bubble_fields rdb %h ext %h ra %0d rb %0d rw %0d exp 66/77/1/2/3", s_rdb_ex, s_ext_ex, s_ra_ex, s_rb_ex, s_rw_ex); end
        s_valid_id = 1'b0; s_ctrl_id = 5'h0;
        tick();
        n_checks++; if (s_valid_ex !== 1'b0 || s_ctrl_ex !== 5'h0) begin n_fail++; $display("FAIL bubble_mask valid %b ctrl %b exp 0/00000", s_valid_ex, s_ctrl_ex); end
        n_checks++; if (s_rda_ex !== 32'h55) begin n_fail++; $display("FAIL bubble_payload rda %h exp 55", s_rda_ex); end
    endtask

    task automatic test_reset_midstream();
        s_ready_ex = 1'b0;
        s_valid_id = 1'b1; s_ctrl_id = 5'h15;
        s_rda_id = 32'hA1;
        tick();
        s_rda_id = 32'hA2;
        tick();
        n_checks++; if (s_occ !== 2'd2 || s_ctrl_ex !== 5'h15) begin n_fail++; $display("FAIL rst_fill occ %0d ctrl %h exp 2/15", s_occ, s_ctrl_ex); end
        s_valid_id = 1'b0; s_ctrl_id = 5'h0;
        #1 reset = 1'b0;
        #1;
        n_checks++; if (s_valid_ex !== 1'b0 || s_occ !== 2'd0) begin n_fail++; $display("FAIL rst_async valid %b occ %0d exp 0/0", s_valid_ex, s_occ); end
        n_checks++; if (s_ready_id !== 1'b1 || s_ctrl_ex !== 5'h0 || s_rda_ex !== 32'h0) begin n_fail++; $display("FAIL rst_async_out ready %b ctrl %h rda %h exp 1/0/0", s_ready_id, s_ctrl_ex, s_rda_ex); end
        #1 reset = 1'b1;
        s_ready_ex = 1'b1; s_valid_id = 1'b1; s_rda_id = 32'hB1;
        tick();
        n_checks++; if (s_valid_ex !== 1'b1 || s_rda_ex !== 32'hB1) begin n_fail++; $display("FAIL rst_first_accept valid %b rda %h exp 1/b1", s_valid_ex, s_rda_ex); end
        s_valid_id = 1'b0;
        tick();
    endtask

    task automatic test_no_skid();
        n_ready_ex = 1'b0;
        n_valid_id = 1'b1; n_rda_id = 32'h11;
        #1;
        n_checks++; if (n_ready_id !== 1'b1) begin n_fail++; $display("FAIL nskid_empty_ready ready %b exp 1", n_ready_id); end
        tick();
        n_rda_id = 32'h22;
        #1;
        n_checks++; if (n_ready_id !== 1'b0 || n_occ !== 2'd1 || n_rda_ex !== 32'h11) begin n_fail++; $display("FAIL nskid_stall ready %b occ %0d rda %h exp 0/1/11", n_ready_id, n_occ, n_rda_ex); end
        tick();
        n_checks++; if (n_rda_ex !== 32'h11 || n_occ !== 2'd1) begin n_fail++; $display("FAIL nskid_hold rda %h occ %0d exp 11/1", n_rda_ex, n_occ); end
        n_ready_ex = 1'b1;
        #1;
        n_checks++; if (n_ready_id !== 1'b1) begin n_fail++; $display("FAIL nskid_comb_ready ready %b exp 1", n_ready_id); end
        tick();
        n_checks++; if (n_rda_ex !== 32'h22 || n_occ !== 2'd1 || n_valid_ex !== 1'b1) begin n_fail++; $display("FAIL nskid_replace rda %h occ %0d valid %b exp 22/1/1", n_rda_ex, n_occ, n_valid_ex); end
        n_valid_id = 1'b0;
        tick();
        n_checks++; if (n_valid_ex !== 1'b0 || n_occ !== 2'd0) begin n_fail++; $display("FAIL nskid_drain valid %b occ %0d exp 0/0", n_valid_ex, n_occ); end
    endtask

    initial begin
        #12 reset = 1'b1;
        #1;
        test_reset();
        test_streaming();
        test_stall();
        test_flush();
        test_bubble();
        test_reset_midstream();
        test_no_skid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/id_ex_stage_reg.md
# id_ex_stage_reg

Parametrised ID→EX pipeline register with a valid/ready handshake, flush, and an optional skid entry. It captures register-file read data, immediate, register addresses and a packed control word from decode, and presents them to execute. Back-pressure from EX stalls ID without losing an instruction. Flush kills in-flight contents for branch/hazard recovery.

## Interface
- `N`, 32: data width of `rda`, `rdb`, `extended`.
- `RW`, 5: register-address width of `ra`, `rb`, `rw`.
- `C`, 5: control-word width; bit map comes from the shared package.
- `SKID`, 1: 1 = two-entry skid (registered `ready_id`); 0 = single entry (combinational `ready_id`).

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low; asserting clears all state immediately.
- `valid_id` in 1: ID offers an instruction.
- `ready_id` out 1: stage accepts this cycle.
- `rda_id`, `rdb_id`, `extended_id` in N each: operands and immediate.
- `ra_id`, `rb_id`, `rw_id` in RW each: source and destination addresses.
- `ctrl_id` in C: {wm, wd_selector, alu_func, opb_selector, wr_en}, with wr_en at bit 0.
- `flush` in 1: kill all held and incoming entries.
- `valid_ex` out 1: output entry valid.
- `ready_ex` in 1: EX consumes this cycle.
- `rda_ex`, `rdb_ex`, `extended_ex` out N each; `ra_ex`, `rb_ex`, `rw_ex` out RW each; `ctrl_ex` out C.
- `occupancy` out 2: entries held (0..2; at most 1 when SKID=0).

## Operation
- Handshakes:
  - in_fire = `valid_id` & `ready_id`.
  - out_fire = `valid_ex` & `ready_ex`.
- Storage: main slot drives the `_ex` outputs. The skid slot exists only when SKID=1.
- States: EMPTY, FULL, SKID_FULL (SKID_FULL unreachable when SKID=0).
- EMPTY: in_fire → load main, go FULL.
- FULL:
  - in_fire & out_fire → load main with new entry, stay FULL.
  - in_fire & !out_fire → load skid, go SKID_FULL. This requires SKID=1; with SKID=0, `ready_id` is low in this case.
  - !in_fire & out_fire → go EMPTY.
- SKID_FULL:
  - `ready_id`=0.
  - out_fire → skid moves to main, go FULL.
- `ready_id`:
  - SKID=1: `ready_id` = (state != SKID_FULL). It is registered and independent of `ready_ex`.
  - SKID=0: `ready_id` = !`valid_ex` | `ready_ex`.
- `valid_ex` = (state != EMPTY).
- Data stability: while `valid_ex` & !`ready_ex`, all `_ex` outputs hold constant.
- Flush:
  - Next state is EMPTY.
  - An entry offered in the same cycle is dropped, even if in_fire.
  - Flush overrides every transition.
- Payload on flush: payload registers are not cleared. `ctrl_ex` is forced to 0 whenever `valid_ex`=0, so wr_en/wm cannot leak from a bubble.
- Ordering: strict FIFO. No entry is duplicated or reordered.

## Timing
- Latency: 1 cycle. An entry accepted at edge k is visible on `_ex` after edge k.
- Throughput: 1 entry/cycle when `ready_ex` is held high.
- Reset state:
  - State EMPTY; `valid_ex`=0; `occupancy`=0.
  - `ready_id`=1 in both modes.
  - All `_ex` data, address and ctrl outputs are 0.
  - Both slots are cleared asynchronously.
- Reset mid-operation: all entries are discarded. The first accept is possible on the first rising edge after deassertion.
- Stall release in SKID_FULL: `ready_id` rises in the cycle after the out_fire that vacates the skid slot.

## Structure
- Package `pipe_pkg`:
  - `stage_state_t` enum {EMPTY, FULL, SKID_FULL}.
  - Ctrl bit-index constants: `CTRL_WR_EN`=0, `CTRL_OPB_SEL`=1, `CTRL_ALU_FUNC`=2, `CTRL_WD_SEL`=3, `CTRL_WM`=4.
  - Default widths.
- Sub-module `pipe_slot`:
  - One payload register (N, RW, C parameters) with load enable and asynchronous active-low clear.
  - Instantiated once for main, and once more under `generate` when SKID=1.
- Top level: state machine, handshake logic, ctrl bubble masking, and the slot mux.

## Test plan
- Reset (SKID=1): reset low mid-stream with 2 entries held → `valid_ex`=0, `occupancy`=0, `ready_id`=1, `ctrl_ex`=0 immediately (asynchronous).
- Streaming: `ready_ex`=1, 8 back-to-back entries with `rda_id`=0x1..0x8 → `rda_ex` shows 0x1..0x8 on consecutive cycles, one cycle late; `occupancy`=1 throughout.
- Stall (SKID=1): `ready_ex`=0, entries A=0xAAAA, B=0xBBBB, C=0xCCCC offered back-to-back → A and B accepted, `occupancy`=2, `ready_id`=0, C held by the source. Then `ready_ex`=1 → EX sees A, B, C in order.
- Flush: flush in SKID_FULL while new entry D is offered → next cycle `valid_ex`=0, `occupancy`=0, D never appears at EX.
- SKID=0: `ready_ex`=0 with main full → `ready_id`=0 in the same cycle. Then `ready_ex`=1 with an offer → in_fire & out_fire in one cycle, main replaced.
- Bubble masking: valid entry with `ctrl_id`=5'b11111 consumed, then no new offer → `ctrl_ex`=0 while `valid_ex`=0.
